// File: rtl/nes_poll_scheduler_if.sv
// rtl/nes_poll_scheduler_if.sv - pad pin and game-side signal bundle for nes_poll_scheduler
interface nes_poll_scheduler_if;
    logic       poll_req;
    logic       data_p1;
    logic       data_p2;
    logic       latch;
    logic       nes_clk;
    logic [7:0] buttons_p1;
    logic [7:0] buttons_p2;
    logic [7:0] pressed_p1;
    logic [7:0] pressed_p2;
    logic       valid;
    logic       busy;
    logic       missed;

    // System / pad side: issues requests, drives pad data, observes results.
    modport master (
        output poll_req,
        output data_p1,
        output data_p2,
        input  latch,
        input  nes_clk,
        input  buttons_p1,
        input  buttons_p2,
        input  pressed_p1,
        input  pressed_p2,
        input  valid,
        input  busy,
        input  missed
    );

    // Scheduler side.
    modport slave (
        input  poll_req,
        input  data_p1,
        input  data_p2,
        output latch,
        output nes_clk,
        output buttons_p1,
        output buttons_p2,
        output pressed_p1,
        output pressed_p2,
        output valid,
        output busy,
        output missed
    );
endinterface

// File: rtl/nes_poll_scheduler.sv
// rtl/nes_poll_scheduler.sv - two-pad NES serial poll sequencer with atomic commit and press edges
module nes_poll_scheduler #(
    parameter int unsigned LATCH_CYCLES    = 600,
    parameter int unsigned HALF_CYCLES     = 300,
    parameter int unsigned POLL_PERIOD     = 833333,
    parameter bit          DATA_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nes_poll_scheduler_if.slave  bus
);

    localparam int unsigned PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int          PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CLK_HI,
        S_CLK_LO,
        S_COMMIT
    } state_t;

    state_t         state;
    logic [PW-1:0]  phase;
    logic [2:0]     bit_idx;
    logic           pending;
    logic [1:0]     sync_p1;
    logic [1:0]     sync_p2;
    logic [7:0]     capture_p1;
    logic [7:0]     capture_p2;
    logic [7:0]     next_p1;
    logic [7:0]     next_p2;
    logic           bit_p1;
    logic           bit_p2;
    logic           timer_wrap;
    logic           req;

    logic           latch_q;
    logic           nes_clk_q;
    logic [7:0]     buttons_p1_q;
    logic [7:0]     buttons_p2_q;
    logic [7:0]     pressed_p1_q;
    logic [7:0]     pressed_p2_q;
    logic           valid_q;
    logic           busy_q;
    logic           missed_q;

    // Free-running frame timer; a zero period removes it entirely.
    generate
        if (POLL_PERIOD > 0) begin : g_timer
            localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
            logic [TW-1:0] timer;

            assign timer_wrap = (timer == TW'(POLL_PERIOD - 1));

            // Count 0..POLL_PERIOD-1 and wrap.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    timer <= '0;
                end else if (timer_wrap) begin
                    timer <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end else begin : g_no_timer
            assign timer_wrap = 1'b0;
        end
    endgenerate

    // Both sources collapse into one request, so a coincident pair counts once.
    assign req = bus.poll_req | timer_wrap;

    // Pad data arrives asynchronously; two flops before any sampling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p1 <= 2'b00;
            sync_p2 <= 2'b00;
        end else begin
            sync_p1 <= {sync_p1[0], bus.data_p1};
            sync_p2 <= {sync_p2[0], bus.data_p2};
        end
    end

    // Normalise polarity so a captured 1 always means pressed.
    assign bit_p1 = sync_p1[1] ^ DATA_ACTIVE_LOW;
    assign bit_p2 = sync_p2[1] ^ DATA_ACTIVE_LOW;

    // Capture image with the current bit slotted in, so bit 7 can commit on the same edge.
    always_comb begin
        next_p1          = capture_p1;
        next_p2          = capture_p2;
        next_p1[bit_idx] = bit_p1;
        next_p2[bit_idx] = bit_p2;
    end

    // Sweep sequencer with request queueing; all pin and status outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            phase        <= '0;
            bit_idx      <= 3'd0;
            pending      <= 1'b0;
            capture_p1   <= 8'h00;
            capture_p2   <= 8'h00;
            latch_q      <= 1'b0;
            nes_clk_q    <= 1'b0;
            buttons_p1_q <= 8'h00;
            buttons_p2_q <= 8'h00;
            pressed_p1_q <= 8'h00;
            pressed_p2_q <= 8'h00;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            missed_q     <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            missed_q     <= 1'b0;
            pressed_p1_q <= 8'h00;
            pressed_p2_q <= 8'h00;

            // A request that cannot start now is parked once, then dropped.
            if (state != S_IDLE && req) begin
                if (!pending) begin
                    pending <= 1'b1;
                end else begin
                    missed_q <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (req || pending) begin
                        state   <= S_LATCH;
                        phase   <= '0;
                        bit_idx <= 3'd0;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        pending <= 1'b0;
                        // A fresh request landing while the queued one is taken is lost.
                        if (req && pending) begin
                            missed_q <= 1'b1;
                        end
                    end
                end

                S_LATCH: begin
                    if (phase == PW'(LATCH_CYCLES - 1)) begin
                        capture_p1 <= next_p1;
                        capture_p2 <= next_p2;
                        latch_q    <= 1'b0;
                        nes_clk_q  <= 1'b1;
                        phase      <= '0;
                        bit_idx    <= 3'd1;
                        state      <= S_CLK_HI;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end

                S_CLK_HI: begin
                    if (phase == PW'(HALF_CYCLES - 1)) begin
                        nes_clk_q <= 1'b0;
                        phase     <= '0;
                        state     <= S_CLK_LO;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end

                S_CLK_LO: begin
                    if (phase == PW'(HALF_CYCLES - 1)) begin
                        capture_p1 <= next_p1;
                        capture_p2 <= next_p2;
                        phase      <= '0;
                        if (bit_idx == 3'd7) begin
                            buttons_p1_q <= next_p1;
                            buttons_p2_q <= next_p2;
                            pressed_p1_q <= next_p1 & ~buttons_p1_q;
                            pressed_p2_q <= next_p2 & ~buttons_p2_q;
                            valid_q      <= 1'b1;
                            state        <= S_COMMIT;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            nes_clk_q <= 1'b1;
                            state     <= S_CLK_HI;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end

                S_COMMIT: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.latch      = latch_q;
    assign bus.nes_clk    = nes_clk_q;
    assign bus.buttons_p1 = buttons_p1_q;
    assign bus.buttons_p2 = buttons_p2_q;
    assign bus.pressed_p1 = pressed_p1_q;
    assign bus.pressed_p2 = pressed_p2_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;
    assign bus.missed     = missed_q;

endmodule
